// File: rtl/move_tick_scheduler_pkg.sv
// Shared constants, FSM state encodings and the debug view of the move tick scheduler.
package move_tick_scheduler_pkg;

    // Direction encoding presented to the processor.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // PS2 set-2 scan codes of interest.
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic {
        K_IDLE  = 1'b0,
        K_BREAK = 1'b1
    } kbd_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_REQ  = 1'b1
    } req_state_t;

    // Internal state brought out so checkers can watch both FSMs and the held key.
    typedef struct packed {
        kbd_state_t kbd_state;
        req_state_t req_state;
        logic       key_valid;
        logic [1:0] key_dir;
    } dbg_t;

    // Make code that belongs to a held direction; used to match break codes.
    function automatic logic [7:0] dir_to_code(input logic [1:0] dir);
        logic [7:0] code;
        case (dir)
            DIR_UP:    code = SC_W;
            DIR_RIGHT: code = SC_D;
            DIR_DOWN:  code = SC_S;
            default:   code = SC_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/move_tick_scheduler_if.sv
// Move request handshake between the scheduler (master) and the processor (slave).
// Handshake: the master raises move_req with move_dir and holds both stable until
// it samples move_ack=1 on a clock edge; move_req drops on the following cycle.
// move_ack while move_req=0 has no effect.
interface move_tick_scheduler_if;
    logic       move_req;
    logic [1:0] move_dir;
    logic       move_ack;

    modport master (output move_req, output move_dir, input move_ack);
    modport slave  (input move_req, input move_dir, output move_ack);
endinterface

// File: rtl/move_tick_scheduler_ps2_dir_decoder.sv
// Turns the PS2 byte stream into a held WASD direction (make sets, break of the
// held key clears; the newest make wins).
module ps2_dir_decoder
    import move_tick_scheduler_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic [1:0] key_dir,
    output logic       key_valid,
    output kbd_state_t kbd_state
);

    kbd_state_t state_q, state_d;
    logic [1:0] key_dir_d;
    logic       key_valid_d;

    // State and held-key registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= K_IDLE;
            key_dir   <= DIR_UP;
            key_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_dir   <= key_dir_d;
            key_valid <= key_valid_d;
        end
    end

    // Next state: bytes are only acted on when the strobe is high; E0 and
    // unknown bytes fall through as no-ops.
    always_comb begin
        state_d     = state_q;
        key_dir_d   = key_dir;
        key_valid_d = key_valid;
        if (ps2_key_pressed) begin
            case (state_q)
                K_IDLE: begin
                    case (ps2_out)
                        SC_W:     begin key_dir_d = DIR_UP;    key_valid_d = 1'b1; end
                        SC_D:     begin key_dir_d = DIR_RIGHT; key_valid_d = 1'b1; end
                        SC_S:     begin key_dir_d = DIR_DOWN;  key_valid_d = 1'b1; end
                        SC_A:     begin key_dir_d = DIR_LEFT;  key_valid_d = 1'b1; end
                        SC_BREAK: state_d = K_BREAK;
                        default:  ;
                    endcase
                end
                default: begin
                    // Releasing a key other than the held one leaves the direction alone.
                    if (ps2_out == dir_to_code(key_dir)) key_valid_d = 1'b0;
                    state_d = K_IDLE;
                end
            endcase
        end
    end

    assign kbd_state = state_q;

endmodule

// File: rtl/move_tick_scheduler.sv
// Game-rate scheduler: picks a direction (switches or keyboard), divides the clock
// into game ticks, issues one move request per tick and runs the powerup countdown.
module move_tick_scheduler
    import move_tick_scheduler_pkg::*;
#(
    parameter int TICK_DIV      = 833_333,
    parameter int CNT_W         = 20,
    parameter int POWERUP_TICKS = 300
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ps2_key_pressed,
    input  logic [7:0]              ps2_out,
    input  logic                    sw_mode,
    input  logic                    sw_up,
    input  logic                    sw_right,
    input  logic                    sw_down,
    input  logic                    sw_left,
    input  logic                    powerup_start,
    move_tick_scheduler_if.master   move_bus,
    output logic                    tick,
    output logic                    powerup_active,
    output logic [15:0]             powerup_remaining,
    output logic [7:0]              missed_ticks,
    output dbg_t                    dbg
);

    logic [CNT_W-1:0] tick_cnt;
    logic [1:0]       key_dir;
    logic             key_valid;
    kbd_state_t       kbd_state;
    logic [1:0]       dir_sel;
    logic             dir_valid;
    req_state_t       req_state_q, req_state_d;
    logic             dir_load;
    logic [1:0]       move_dir_q;

    ps2_dir_decoder u_decoder (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_out         (ps2_out),
        .key_dir         (key_dir),
        .key_valid       (key_valid),
        .kbd_state       (kbd_state)
    );

    // Direction source: switches with fixed priority, or the held key.
    always_comb begin
        dir_sel   = key_dir;
        dir_valid = key_valid;
        if (sw_mode) begin
            dir_valid = sw_up | sw_right | sw_down | sw_left;
            if (sw_up)         dir_sel = DIR_UP;
            else if (sw_right) dir_sel = DIR_RIGHT;
            else if (sw_down)  dir_sel = DIR_DOWN;
            else               dir_sel = DIR_LEFT;
        end
    end

    // Free-running game tick divider.
    always_ff @(posedge clock) begin
        if (reset)                                  tick_cnt <= '0;
        else if (tick_cnt == CNT_W'(TICK_DIV - 1))  tick_cnt <= '0;
        else                                        tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign tick = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // Request FSM state register.
    always_ff @(posedge clock) begin
        if (reset) req_state_q <= R_IDLE;
        else       req_state_q <= req_state_d;
    end

    // Request FSM next state: a tick with a direction opens a request, ack closes it.
    always_comb begin
        req_state_d = req_state_q;
        dir_load    = 1'b0;
        case (req_state_q)
            R_IDLE: begin
                if (tick && dir_valid) begin
                    req_state_d = R_REQ;
                    dir_load    = 1'b1;
                end
            end
            default: begin
                if (move_bus.move_ack) req_state_d = R_IDLE;
            end
        endcase
    end

    // Direction is captured once per request and frozen until the ack.
    always_ff @(posedge clock) begin
        if (reset)         move_dir_q <= DIR_UP;
        else if (dir_load) move_dir_q <= dir_sel;
    end

    assign move_bus.move_req = (req_state_q == R_REQ);
    assign move_bus.move_dir = move_dir_q;

    // Ticks that arrive while a request is still outstanding are dropped and counted.
    always_ff @(posedge clock) begin
        if (reset)
            missed_ticks <= 8'd0;
        else if (tick && (req_state_q == R_REQ) && (missed_ticks != 8'hFF))
            missed_ticks <= missed_ticks + 8'd1;
    end

    // Powerup countdown: a start (re)loads and takes precedence over a tick.
    always_ff @(posedge clock) begin
        if (reset)
            powerup_remaining <= 16'd0;
        else if (powerup_start)
            powerup_remaining <= 16'(POWERUP_TICKS);
        else if (tick && (powerup_remaining != 16'd0))
            powerup_remaining <= powerup_remaining - 16'd1;
    end

    assign powerup_active = (powerup_remaining != 16'd0);

    // Debug view of both FSMs and the held key.
    always_comb begin
        dbg           = '0;
        dbg.kbd_state = kbd_state;
        dbg.req_state = req_state_q;
        dbg.key_valid = key_valid;
        dbg.key_dir   = key_dir;
    end

endmodule

// File: tb/tb_move_tick_scheduler.sv
// Bench for move_tick_scheduler: directed scenarios with literal expectations,
// then random traffic, all shadowed by a cycle-level behavioural model.
module tb_move_tick_scheduler;
    import move_tick_scheduler_pkg::*;

    localparam int TICK_DIV      = 10;
    localparam int POWERUP_TICKS = 3;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_key_pressed = 1'b0;
    logic [7:0]  ps2_out = 8'h00;
    logic        sw_mode = 1'b0;
    logic        sw_up = 1'b0, sw_right = 1'b0, sw_down = 1'b0, sw_left = 1'b0;
    logic        powerup_start = 1'b0;
    logic        tick, powerup_active;
    logic [15:0] powerup_remaining;
    logic [7:0]  missed_ticks;
    dbg_t        dbg;

    always #5 clock = ~clock;

    move_tick_scheduler_if bus ();
    initial bus.move_ack = 1'b0;

    move_tick_scheduler #(
        .TICK_DIV      (TICK_DIV),
        .CNT_W         (4),
        .POWERUP_TICKS (POWERUP_TICKS)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ps2_key_pressed   (ps2_key_pressed),
        .ps2_out           (ps2_out),
        .sw_mode           (sw_mode),
        .sw_up             (sw_up),
        .sw_right          (sw_right),
        .sw_down           (sw_down),
        .sw_left           (sw_left),
        .powerup_start     (powerup_start),
        .move_bus          (bus.master),
        .tick              (tick),
        .powerup_active    (powerup_active),
        .powerup_remaining (powerup_remaining),
        .missed_ticks      (missed_ticks),
        .dbg               (dbg)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    logic [1:0] exp_q[$];
    logic [7:0] key_code [4] = '{8'h1D, 8'h23, 8'h1B, 8'h1C};
    int         m_cyc = 0;        // cycles since reset, modulo the tick period
    bit         m_req = 0;
    logic [1:0] m_dir = 0;
    int         m_miss = 0;
    int         m_rem = 0;
    bit         m_key_valid = 0;
    logic [1:0] m_key_dir = 0;
    bit         m_in_break = 0;
    bit         prev_req = 0;
    bit         m_tick_now;
    bit         m_dv;
    logic [1:0] m_dsel;

    always @(posedge clock) begin
        if (reset) begin
            m_cyc = 0; m_req = 0; m_dir = 0; m_miss = 0; m_rem = 0;
            m_key_valid = 0; m_key_dir = 0; m_in_break = 0;
            exp_q.delete();
        end else begin
            m_tick_now = (m_cyc == TICK_DIV - 1);
            if (sw_mode) begin
                m_dv   = sw_up | sw_right | sw_down | sw_left;
                m_dsel = sw_up ? 2'd0 : sw_right ? 2'd1 : sw_down ? 2'd2 : 2'd3;
            end else begin
                m_dv   = m_key_valid;
                m_dsel = m_key_dir;
            end
            if (m_tick_now && m_req && m_miss < 255) m_miss++;
            if (!m_req) begin
                if (m_tick_now && m_dv) begin
                    m_req = 1; m_dir = m_dsel; exp_q.push_back(m_dsel);
                end
            end else if (bus.move_ack) begin
                m_req = 0;
            end
            if (powerup_start)                m_rem = POWERUP_TICKS;
            else if (m_tick_now && m_rem > 0) m_rem--;
            if (ps2_key_pressed) begin
                if (m_in_break) begin
                    if (ps2_out == key_code[m_key_dir]) m_key_valid = 0;
                    m_in_break = 0;
                end else if (ps2_out == 8'hF0) begin
                    m_in_break = 1;
                end else begin
                    for (int i = 0; i < 4; i++)
                        if (ps2_out == key_code[i]) begin m_key_dir = 2'(i); m_key_valid = 1; end
                end
            end
            m_cyc = (m_cyc + 1) % TICK_DIV;
        end
        #1;
        if (bus.move_req && !prev_req) begin
            if (exp_q.size() == 0) check("sb_unexpected_req", 1, 0);
            else                   check("sb_req_dir", 32'(bus.move_dir), 32'(exp_q.pop_front()));
        end
        prev_req = bus.move_req;
        check("m_tick", 32'(tick), 32'(m_cyc == TICK_DIV - 1));
        check("m_move_req", 32'(bus.move_req), 32'(m_req));
        if (m_req) check("m_move_dir", 32'(bus.move_dir), 32'(m_dir));
        check("m_missed", 32'(missed_ticks), 32'(m_miss));
        check("m_remaining", 32'(powerup_remaining), 32'(m_rem));
        check("m_active", 32'(powerup_active), 32'(m_rem != 0));
        check("m_key_valid", 32'(dbg.key_valid), 32'(m_key_valid));
        if (m_key_valid) check("m_key_dir", 32'(dbg.key_dir), 32'(m_key_dir));
        check("m_kbd_state", 32'(dbg.kbd_state), 32'(m_in_break ? K_BREAK : K_IDLE));
        check("m_req_state", 32'(dbg.req_state), 32'(m_req ? R_REQ : R_IDLE));
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic send_byte(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_out         = b;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        @(negedge clock);
    endtask

    // Returns at the negedge just before a tick edge.
    task automatic wait_tick();
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            @(negedge clock);
            if (tick) return;
        end
        check("wait_tick_timeout", 1, 0);
    endtask

    task automatic wait_req();
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            @(negedge clock);
            if (bus.move_req) return;
        end
        check("wait_req_timeout", 1, 0);
    endtask

    task automatic ack_pulse(input int n);
        bus.move_ack = 1'b1;
        repeat (n) @(negedge clock);
        bus.move_ack = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // 1: reset in the middle of a request
        sw_mode = 1'b1; sw_up = 1'b1;
        wait_req();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("s1_rst_req", 32'(bus.move_req), 0);
            check("s1_rst_dir", 32'(bus.move_dir), 0);
            check("s1_rst_tick", 32'(tick), 0);
            check("s1_rst_missed", 32'(missed_ticks), 0);
            check("s1_rst_rem", 32'(powerup_remaining), 0);
            check("s1_rst_active", 32'(powerup_active), 0);
        end
        reset = 1'b0; sw_up = 1'b0;
        repeat (10) begin
            @(negedge clock);
            check("s1_no_req_after_reset", 32'(bus.move_req), 0);
        end

        // 2: keyboard make/break handling
        sw_mode = 1'b0;
        send_byte(8'h1D);
        send_byte(8'h23);
        check("s2_key_dir", 32'(dbg.key_dir), 1);
        check("s2_key_valid", 32'(dbg.key_valid), 1);
        wait_tick();
        @(negedge clock);
        check("s2_req", 32'(bus.move_req), 1);
        check("s2_dir", 32'(bus.move_dir), 1);
        ack_pulse(1);
        check("s2_req_dropped", 32'(bus.move_req), 0);
        send_byte(8'hF0); send_byte(8'h1D);
        check("s2_other_break_valid", 32'(dbg.key_valid), 1);
        check("s2_other_break_dir", 32'(dbg.key_dir), 1);
        send_byte(8'hF0); send_byte(8'h23);
        check("s2_held_break_valid", 32'(dbg.key_valid), 0);
        ack_pulse(3);
        repeat (2) begin
            wait_tick();
            @(negedge clock);
            check("s2_no_req_released", 32'(bus.move_req), 0);
        end

        // 3: switch priority and handshake latency
        sw_mode = 1'b1; sw_up = 1'b1; sw_left = 1'b1;
        wait_tick();
        check("s3_idle_before_tick", 32'(bus.move_req), 0);
        @(negedge clock);
        check("s3_req", 32'(bus.move_req), 1);
        check("s3_dir_up", 32'(bus.move_dir), 0);
        repeat (2) @(negedge clock);
        ack_pulse(1);
        check("s3_req_low_after_ack", 32'(bus.move_req), 0);

        // 4: missed ticks while stalled, then saturation
        sw_left = 1'b0;
        wait_tick();
        @(negedge clock);
        check("s4_req", 32'(bus.move_req), 1);
        sw_up = 1'b0; sw_right = 1'b1;
        repeat (3) wait_tick();
        @(negedge clock);
        check("s4_missed_3", 32'(missed_ticks), 3);
        check("s4_dir_frozen", 32'(bus.move_dir), 0);
        repeat (257) wait_tick();
        @(negedge clock);
        check("s4_missed_sat", 32'(missed_ticks), 255);
        sw_right = 1'b0;
        ack_pulse(1);
        check("s4_req_cleared", 32'(bus.move_req), 0);

        // 5: powerup countdown
        wait_tick();
        @(negedge clock);
        powerup_start = 1'b1;
        @(negedge clock);
        powerup_start = 1'b0;
        check("s5_loaded", 32'(powerup_remaining), 3);
        check("s5_active", 32'(powerup_active), 1);
        repeat (3) wait_tick();
        @(negedge clock);
        check("s5_expired", 32'(powerup_remaining), 0);
        check("s5_inactive", 32'(powerup_active), 0);
        wait_tick();
        powerup_start = 1'b1;
        @(negedge clock);
        powerup_start = 1'b0;
        check("s5_load_beats_tick", 32'(powerup_remaining), 3);

        // 6: extended and unrelated bytes are ignored
        sw_mode = 1'b0;
        send_byte(8'h1C);
        check("s6_key_left", 32'(dbg.key_dir), 3);
        send_byte(8'hE0); send_byte(8'h75); send_byte(8'h12);
        check("s6_valid_kept", 32'(dbg.key_valid), 1);
        check("s6_dir_kept", 32'(dbg.key_dir), 3);
        check("s6_kbd_idle", 32'(dbg.kbd_state), 32'(K_IDLE));
        ack_pulse(3);

        // random traffic against the model
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 499) == 0);
            ps2_key_pressed = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: ps2_out = 8'h1D;
                1: ps2_out = 8'h23;
                2: ps2_out = 8'h1B;
                3: ps2_out = 8'h1C;
                4, 5: ps2_out = 8'hF0;
                6: ps2_out = 8'hE0;
                default: ps2_out = 8'($urandom_range(0, 255));
            endcase
            if ($urandom_range(0, 49) == 0) sw_mode = ~sw_mode;
            if ($urandom_range(0, 19) == 0) begin
                sw_up    = ($urandom_range(0, 3) == 0);
                sw_right = ($urandom_range(0, 3) == 0);
                sw_down  = ($urandom_range(0, 3) == 0);
                sw_left  = ($urandom_range(0, 3) == 0);
            end
            bus.move_ack  = ($urandom_range(0, 5) == 0);
            powerup_start = ($urandom_range(0, 39) == 0);
        end
        reset = 1'b0; ps2_key_pressed = 1'b0; bus.move_ack = 1'b0; powerup_start = 1'b0;
        repeat (3) @(negedge clock);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
